midi_tx_arbiter: RTL

MIDI_TX_ARBITER -- requirements
Module: midi_tx_arbiter

---
 rtl/midi_tx_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/midi_tx_arbiter.sv
// midi_tx_arbiter
//   Round-robin arbiter that lets NUM_REQ byte-stream requesters share one
//   MIDI transmitter. It works at message granularity. Once a requester is
//   granted, it keeps the transmitter until a byte flagged req_last has been
//   fully shifted out, or until the transmitter fails to go busy (timeout).
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   TIMEOUT_CYC  cycles to wait for midi_out_ready to fall after a send pulse
//
// Ports
//   CLOCK_50        clock, all logic on posedge
//   reset_reg_N     asynchronous active-low reset
//   req_valid       per-requester byte available
//   req_data        per-requester byte, requester i at [8i+7:8i]
//   req_last        per-requester end-of-message flag
//   req_ready       one-cycle pulse, byte of requester i consumed
//   grant           one-hot current owner, zero when idle
//   midi_send_byte  one-cycle start pulse to the transmitter
//   midi_out_data   byte being transmitted, held until the transmitter is done
//   midi_out_ready  transmitter idle (1) / shifting (0)
//   busy            arbiter not idle
//   tx_timeout      one-cycle pulse, transmitter never went busy
//
// Optional feature
//   MIDI_RUNNING_STATUS_EN : suppress a channel status byte (80..EF) equal to
//   the last transmitted one. The byte is consumed but not sent.

module midi_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_reg_N,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 midi_send_byte,
  output logic [7:0]           midi_out_data,
  input  logic                 midi_out_ready,
  output logic                 busy,
  output logic                 tx_timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

  state_t             r_state, w_next;
  logic [NUM_REQ-1:0] r_grant, r_ready;
  logic [IW-1:0]      r_owner, r_last_owner, w_pick, w_idx;
  logic               w_any;
  logic [CW-1:0]      r_cnt;
  logic               r_last, r_send, r_to;
  logic [7:0]         r_data, w_own_data;
  logic               w_own_valid, w_own_last, w_suppress;
  logic               w_take, w_fire, w_tx, w_to, w_rel;

  assign req_ready      = r_ready;
  assign grant          = r_grant;
  assign midi_send_byte = r_send;
  assign midi_out_data  = r_data;
  assign tx_timeout     = r_to;
  assign busy           = (r_state != IDLE);

  // Round-robin search. Offsets are scanned from farthest to nearest, so the
  // first valid requester after last_owner is the one that sticks.
  always_comb begin
    w_pick = '0;
    w_idx  = '0;
    w_any  = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IW'((int'(r_last_owner) + k) % NUM_REQ);
      if (req_valid[w_idx]) begin
        w_pick = w_idx;
        w_any  = 1'b1;
      end
    end
  end

  // Mux out the current owner's lane.
  always_comb begin
    w_own_data  = 8'h00;
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == r_owner) begin
        w_own_data  = req_data[8*i +: 8];
        w_own_valid = req_valid[i];
        w_own_last  = req_last[i];
      end
    end
  end

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] r_last_status;

  // Only bytes that actually go out on the wire change running status.
  // Data bytes and system real-time bytes leave it unchanged.
  always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_last_status <= 8'h00;
    end else if (w_tx) begin
      if (w_own_data >= 8'h80 && w_own_data <= 8'hEF)
        r_last_status <= w_own_data;
      else if (w_own_data >= 8'hF0 && w_own_data <= 8'hF7)
        r_last_status <= 8'h00;
    end
  end

  assign w_suppress = (w_own_data >= 8'h80) && (w_own_data <= 8'hEF) &&
                      (w_own_data == r_last_status);
`else
  assign w_suppress = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
    if (!reset_reg_N) r_state <= IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    w_fire = 1'b0;
    w_tx   = 1'b0;
    w_to   = 1'b0;
    w_rel  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_take = 1'b1;
          w_next = SEND;
        end
      end
      SEND: begin
        if (midi_out_ready && w_own_valid) begin
          w_fire = 1'b1;
          w_tx   = !w_suppress;
          // A suppressed byte never makes the transmitter busy. Go straight
          // to WAIT_DONE, which sees ready=1 and applies the captured last.
          w_next = w_suppress ? WAIT_DONE : WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!midi_out_ready) begin
          w_next = WAIT_DONE;
        end else if (r_cnt >= CW'(TIMEOUT_CYC - 1)) begin
          w_to   = 1'b1;
          w_rel  = 1'b1;
          w_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (midi_out_ready) begin
          if (r_last) begin
            w_rel  = 1'b1;
            w_next = IDLE;
          end else begin
            w_next = HOLD;
          end
        end
      end
      HOLD:    w_next = SEND;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_grant      <= '0;
      r_ready      <= '0;
      r_owner      <= '0;
      r_last_owner <= IW'(NUM_REQ - 1);
      r_cnt        <= '0;
      r_last       <= 1'b0;
      r_send       <= 1'b0;
      r_to         <= 1'b0;
      r_data       <= 8'h00;
    end else begin
      r_ready <= '0;
      r_send  <= 1'b0;
      r_to    <= w_to;
      if (w_take) begin
        r_grant <= NUM_REQ'(1) << w_pick;
        r_owner <= w_pick;
      end
      if (w_fire) begin
        r_ready <= NUM_REQ'(1) << r_owner;
        r_last  <= w_own_last;
        r_send  <= w_tx;
        if (w_tx) r_data <= w_own_data;
      end
      // The counter measures cycles since the send pulse. It saturates so
      // that it cannot wrap.
      if (w_fire)
        r_cnt <= '0;
      else if (r_state == WAIT_BUSY && r_cnt != CW'(TIMEOUT_CYC))
        r_cnt <= r_cnt + 1'b1;
      if (w_rel) begin
        r_grant      <= '0;
        r_last_owner <= r_owner;
      end
    end
  end

endmodule
